riscv_ras_ptr_ctrl: RTL and testbench

RISCV_RAS_PTR_CTRL -- requirements
Module: riscv_ras_ptr_ctrl

---
 rtl/riscv_pkg.sv | 13 +
 rtl/riscv_ras_mem.sv | 46 ++++
 rtl/riscv_ras_ptr_ctrl.sv | 146 ++++++++++++++
 tb/tb_riscv_ras_ptr_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared return-address-stack types: FSM state encoding and its width.
package riscv_pkg;

    localparam int RAS_FSM_WIDTH = 3;

    typedef enum logic [RAS_FSM_WIDTH-1:0] {
        RAS_EMPTY   = RAS_FSM_WIDTH'(0),
        RAS_PARTIAL = RAS_FSM_WIDTH'(1),
        RAS_FULL    = RAS_FSM_WIDTH'(2),
        RAS_RECOVER = RAS_FSM_WIDTH'(3)
    } ras_state_e;

endpackage

// File: rtl/riscv_ras_mem.sv
// RAS entry array: one write port, one registered read port (1-cycle latency).
// Read and write to the same slot in one cycle return the old contents.
module riscv_ras_mem #(
    parameter int ADDR_WIDTH = 64,
    parameter int RAS_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         wr_en,
    input  logic [$clog2(RAS_DEPTH)-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0]        wr_dat,
    input  logic                         rd_en,
    input  logic                         rd_clr,
    input  logic [$clog2(RAS_DEPTH)-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0]        rd_dat
);

    logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [ADDR_WIDTH-1:0] rd_dat_d;
    logic [ADDR_WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    // rd_clr lets a failed pop publish a zero address instead of stale data.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = rd_clr ? '0 : mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/riscv_ras_ptr_ctrl.sv
// Speculative return address stack: pointer/count control, commit snapshot, abort recovery.
// Pop data one cycle after the request; no backpressure, every accepted op completes.
module riscv_ras_ptr_ctrl #(
    parameter int ADDR_WIDTH    = 64,
    parameter int RAS_DEPTH     = 16,
    parameter int RAS_FSM_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       enable,
    input  logic                       i_abort,
    input  logic                       i_commit,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_pop_then_push,
    input  logic [ADDR_WIDTH-1:0]      i_push_addr,
    output logic [ADDR_WIDTH-1:0]      o_pop_addr,
    output logic                       o_pop_valid,
    output logic                       o_underflow,
    output logic [$clog2(RAS_DEPTH):0] o_count,
    output logic [RAS_FSM_WIDTH-1:0]   o_fsm_status
);
    import riscv_pkg::*;

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    logic [PW-1:0] tos_q, tos_d, tos_c_q, tos_c_d;
    logic [CW-1:0] count_q, count_d, count_c_q, count_c_d;
    logic          pop_vld_q, pop_vld_d, underflow_q, underflow_d;
    ras_state_e    state_q, state_d;

    logic          ops_ok, do_push, do_pop, do_pp, empty;
    logic          wr_en, rd_en, rd_clr;
    logic [PW-1:0] wr_addr, rd_addr;

    // Push together with pop is folded into pop-then-push.
    assign ops_ok  = enable && !i_abort && (state_q != RAS_RECOVER);
    assign do_pp   = ops_ok && (i_pop_then_push || (i_push && i_pop));
    assign do_push = ops_ok && i_push && !i_pop && !i_pop_then_push;
    assign do_pop  = ops_ok && i_pop && !i_push && !i_pop_then_push;
    assign empty   = (count_q == '0);

    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        tos_c_d     = tos_c_q;
        count_c_d   = count_c_q;
        pop_vld_d   = 1'b0;
        underflow_d = 1'b0;
        state_d     = state_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        rd_clr      = 1'b0;
        wr_addr     = tos_q;
        rd_addr     = tos_q - PW'(1);

        if (i_abort) begin
            tos_d   = tos_c_q;
            count_d = count_c_q;
            state_d = RAS_RECOVER;
        end else begin
            if (do_push || (do_pp && empty)) begin
                // When full, tos already points at the oldest entry.
                wr_en   = 1'b1;
                tos_d   = tos_q + PW'(1);
                count_d = (count_q == FULL_CNT) ? count_q : count_q + CW'(1);
                if (do_pp) begin
                    underflow_d = 1'b1;
                    rd_en       = 1'b1;
                    rd_clr      = 1'b1;
                end
            end else if (do_pop) begin
                rd_en = 1'b1;
                if (empty) begin
                    underflow_d = 1'b1;
                    rd_clr      = 1'b1;
                end else begin
                    pop_vld_d = 1'b1;
                    tos_d     = tos_q - PW'(1);
                    count_d   = count_q - CW'(1);
                end
            end else if (do_pp) begin
                rd_en     = 1'b1;
                pop_vld_d = 1'b1;
                wr_en     = 1'b1;
                wr_addr   = rd_addr;
            end

            if (ops_ok && i_commit) begin
                tos_c_d   = tos_d;
                count_c_d = count_d;
            end

            if (count_d == '0) begin
                state_d = RAS_EMPTY;
            end else if (count_d == FULL_CNT) begin
                state_d = RAS_FULL;
            end else begin
                state_d = RAS_PARTIAL;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tos_q       <= '0;
            count_q     <= '0;
            tos_c_q     <= '0;
            count_c_q   <= '0;
            pop_vld_q   <= 1'b0;
            underflow_q <= 1'b0;
            state_q     <= RAS_EMPTY;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            tos_c_q     <= tos_c_d;
            count_c_q   <= count_c_d;
            pop_vld_q   <= pop_vld_d;
            underflow_q <= underflow_d;
            state_q     <= state_d;
        end
    end

    riscv_ras_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_mem (
        .clk     (clk),
        .nreset  (nreset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (i_push_addr),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rd_addr (rd_addr),
        .rd_dat  (o_pop_addr)
    );

    assign o_pop_valid  = pop_vld_q && enable;
    assign o_underflow  = underflow_q && enable;
    assign o_count      = count_q;
    assign o_fsm_status = RAS_FSM_WIDTH'(state_q);

endmodule

// File: tb/tb_riscv_ras_ptr_ctrl.sv
// Directed scenarios plus random traffic, checked every cycle against a behavioural stack model.
module tb_riscv_ras_ptr_ctrl;

    localparam int AW = 64;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          enable = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_commit = 1'b0;
    logic          i_push = 1'b0;
    logic          i_pop = 1'b0;
    logic          i_pop_then_push = 1'b0;
    logic [AW-1:0] i_push_addr = '0;
    logic [AW-1:0] o_pop_addr;
    logic          o_pop_valid;
    logic          o_underflow;
    logic [4:0]    o_count;
    logic [2:0]    o_fsm_status;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: circular array with integer pointers.
    logic [AW-1:0] m_mem [D];
    int            m_tos, m_cnt, m_tosc, m_cntc;
    bit            m_rec, m_vld, m_uf;
    logic [AW-1:0] m_pop_addr;

    riscv_ras_ptr_ctrl #(
        .ADDR_WIDTH    (AW),
        .RAS_DEPTH     (D),
        .RAS_FSM_WIDTH (3)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .enable          (enable),
        .i_abort         (i_abort),
        .i_commit        (i_commit),
        .i_push          (i_push),
        .i_pop           (i_pop),
        .i_pop_then_push (i_pop_then_push),
        .i_push_addr     (i_push_addr),
        .o_pop_addr      (o_pop_addr),
        .o_pop_valid     (o_pop_valid),
        .o_underflow     (o_underflow),
        .o_count         (o_count),
        .o_fsm_status    (o_fsm_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_state();
        if (m_rec)         return 3;
        else if (m_cnt==0) return 0;
        else if (m_cnt==D) return 2;
        else               return 1;
    endfunction

    task automatic model_reset();
        m_tos = 0; m_cnt = 0; m_tosc = 0; m_cntc = 0;
        m_rec = 0; m_vld = 0; m_uf = 0; m_pop_addr = '0;
    endtask

    task automatic model_clk(input bit en, input bit ab, input bit cm, input bit pu,
                             input bit po, input bit pp, input logic [AW-1:0] a);
        bit ok, opp, opu, opo;
        int t;
        ok  = en && !ab && !m_rec;
        opp = ok && (pp || (pu && po));
        opu = ok && pu && !po && !pp;
        opo = ok && po && !pu && !pp;
        m_vld = 0;
        m_uf  = 0;
        if (ab) begin
            m_tos = m_tosc;
            m_cnt = m_cntc;
            m_rec = 1;
        end else begin
            if (opu || (opp && m_cnt == 0)) begin
                m_mem[m_tos] = a;
                m_tos = (m_tos + 1) % D;
                if (m_cnt < D) m_cnt++;
                if (opp) begin
                    m_uf = 1;
                    m_pop_addr = '0;
                end
            end else if (opo) begin
                if (m_cnt == 0) begin
                    m_uf = 1;
                    m_pop_addr = '0;
                end else begin
                    m_tos = (m_tos + D - 1) % D;
                    m_pop_addr = m_mem[m_tos];
                    m_vld = 1;
                    m_cnt--;
                end
            end else if (opp) begin
                t = (m_tos + D - 1) % D;
                m_pop_addr = m_mem[t];
                m_vld = 1;
                m_mem[t] = a;
            end
            if (ok && cm) begin
                m_tosc = m_tos;
                m_cntc = m_cnt;
            end
            m_rec = 0;
        end
    endtask

    task automatic compare_all();
        check("count", 64'(o_count), 64'(m_cnt));
        check("state", 64'(o_fsm_status), 64'(exp_state()));
        check("pop_valid", 64'(o_pop_valid), 64'(m_vld && enable));
        check("underflow", 64'(o_underflow), 64'(m_uf && enable));
        check("pop_addr", o_pop_addr, m_pop_addr);
    endtask

    task automatic step(input bit en, input bit ab, input bit cm, input bit pu,
                        input bit po, input bit pp, input logic [AW-1:0] a);
        @(negedge clk);
        enable = en; i_abort = ab; i_commit = cm;
        i_push = pu; i_pop = po; i_pop_then_push = pp; i_push_addr = a;
        @(posedge clk);
        model_clk(en, ab, cm, pu, po, pp, a);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        enable = 1'b0; i_abort = 0; i_commit = 0; i_push = 0; i_pop = 0; i_pop_then_push = 0;
        model_reset();
        #1;
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_state", 64'(o_fsm_status), 64'd0);
        check("rst_valid", 64'(o_pop_valid), 64'd0);
        check("rst_addr", o_pop_addr, 64'd0);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] a;
        bit ab, cm, pu, po, pp, en;

        do_reset();

        // LIFO order
        step(1,0,0,1,0,0, 64'h100);
        step(1,0,0,1,0,0, 64'h200);
        step(1,0,0,1,0,0, 64'h300);
        step(1,0,0,0,1,0, '0); check("lifo_0", o_pop_addr, 64'h300);
        step(1,0,0,0,1,0, '0); check("lifo_1", o_pop_addr, 64'h200);
        step(1,0,0,0,1,0, '0); check("lifo_2", o_pop_addr, 64'h100);
        check("lifo_cnt", 64'(o_count), 64'd0);
        check("lifo_state", 64'(o_fsm_status), 64'd0);

        // overflow wraps over the oldest entry
        do_reset();
        for (int i = 0; i < 17; i++) step(1,0,0,1,0,0, 64'h1000 + 64'(i));
        check("full_cnt", 64'(o_count), 64'd16);
        check("full_state", 64'(o_fsm_status), 64'd2);
        for (int i = 0; i < 16; i++) begin
            step(1,0,0,0,1,0, '0);
            check("full_pop", o_pop_addr, 64'h1010 - 64'(i));
        end

        // underflow
        step(1,0,0,0,1,0, '0);
        check("uf_pulse", 64'(o_underflow), 64'd1);
        check("uf_valid", 64'(o_pop_valid), 64'd0);
        check("uf_cnt", 64'(o_count), 64'd0);
        step(1,0,0,0,0,0, '0);
        check("uf_once", 64'(o_underflow), 64'd0);

        // commit then abort
        do_reset();
        step(1,0,0,1,0,0, 64'hA);
        step(1,0,1,0,0,0, '0);
        step(1,0,0,1,0,0, 64'hB);
        step(1,0,0,1,0,0, 64'hC);
        step(1,1,0,0,0,0, '0);
        check("ab_cnt", 64'(o_count), 64'd1);
        check("ab_rec", 64'(o_fsm_status), 64'd3);
        step(1,0,0,0,0,0, '0);
        check("ab_part", 64'(o_fsm_status), 64'd1);
        step(1,0,0,0,1,0, '0);
        check("ab_pop", o_pop_addr, 64'hA);

        // pop-then-push
        step(1,0,0,1,0,0, 64'h40);
        step(1,0,0,0,0,1, 64'h80);
        check("pp_addr", o_pop_addr, 64'h40);
        check("pp_cnt", 64'(o_count), 64'd1);
        step(1,0,0,0,1,0, '0);
        check("pp_next", o_pop_addr, 64'h80);

        // abort beats push; disabled push ignored
        step(1,0,1,1,0,0, 64'h55);
        step(1,1,0,1,0,0, 64'h66);
        check("abpush_cnt", 64'(o_count), 64'd1);
        step(0,0,0,1,0,0, 64'h77);
        check("dis_cnt", 64'(o_count), 64'd1);

        // reset drops an in-flight pop result
        step(1,0,0,0,1,0, '0);
        check("inflight_vld", 64'(o_pop_valid), 64'd1);
        nreset = 1'b0;
        model_reset();
        #1;
        check("rst_mid_vld", 64'(o_pop_valid), 64'd0);
        check("rst_mid_addr", o_pop_addr, 64'd0);
        @(negedge clk);
        nreset = 1'b1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 9) != 0);
            ab = ($urandom_range(0, 24) == 0);
            cm = ($urandom_range(0, 5) == 0);
            pu = ($urandom_range(0, 2) == 0);
            po = ($urandom_range(0, 2) == 0);
            pp = ($urandom_range(0, 7) == 0);
            a  = {$urandom, $urandom};
            step(en, ab, cm, pu, po, pp, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
